// File: rtl/cache_pkg.sv
// Shared types and constants for the cache refill controller.
package cache_pkg;

   // Default line geometry; the controller recomputes these from its own parameters.
   localparam int CACHE_DATA_W     = 32;
   localparam int CACHE_LINE_WORDS = 4;
   localparam int LINE_BYTES       = CACHE_LINE_WORDS * CACHE_DATA_W / 8;
   localparam int OFFSET_W         = $clog2(LINE_BYTES);

   // One cache line as a packed array of beats, word 0 in the LSBs.
   typedef logic [CACHE_LINE_WORDS-1:0][CACHE_DATA_W-1:0] line_t;

   // Refill sequencing states.
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WB_REQ  = 3'd1,
      WB_DATA = 3'd2,
      RD_REQ  = 3'd3,
      RD_DATA = 3'd4,
      FILL    = 3'd5
   } refill_state_e;

endpackage

// File: rtl/cache_refill_ctrl.sv
// Miss handler: optional dirty-victim write-back burst, then a read burst
// of the missing line, then one fill transfer back to the cache.
module cache_refill_ctrl
   import cache_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int LINE_WORDS = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         miss_valid,
   output logic                         miss_ready,
   input  logic [ADDR_W-1:0]            miss_addr,
   input  logic                         victim_dirty,
   input  logic [ADDR_W-1:0]            victim_addr,
   input  logic [DATA_W*LINE_WORDS-1:0] victim_data,
   output logic                         mem_req_valid,
   input  logic                         mem_req_ready,
   output logic                         mem_req_we,
   output logic [ADDR_W-1:0]            mem_req_addr,
   output logic                         mem_wvalid,
   input  logic                         mem_wready,
   output logic [DATA_W-1:0]            mem_wdata,
   input  logic                         mem_rvalid,
   output logic                         mem_rready,
   input  logic [DATA_W-1:0]            mem_rdata,
   output logic                         fill_valid,
   input  logic                         fill_ready,
   output logic [ADDR_W-1:0]            fill_addr,
   output logic [DATA_W*LINE_WORDS-1:0] fill_data,
   output logic                         busy
);

   localparam int OFF_W  = $clog2(LINE_WORDS * DATA_W / 8);
   localparam int BEAT_W = $clog2(LINE_WORDS);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);
   localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
   localparam logic [BEAT_W-1:0] BEAT_ZERO = BEAT_W'(0);

   // Clear the byte-offset-within-line bits of an address.
   function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
      line_align = addr & ({ADDR_W{1'b1}} << OFF_W);
   endfunction

   refill_state_e                         state_r;
   refill_state_e                         state_s;
   logic [BEAT_W-1:0]                     beat_r;
   logic [ADDR_W-1:0]                     miss_addr_r;
   logic [ADDR_W-1:0]                     victim_addr_r;
   logic [LINE_WORDS-1:0][DATA_W-1:0]     victim_data_r;
   logic [LINE_WORDS-1:0][DATA_W-1:0]     line_r;

   // State register; reset abandons any burst in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state sequencing driven by the handshakes of the current state.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (miss_valid) begin
               state_s = victim_dirty ? WB_REQ : RD_REQ;
            end else begin
               state_s = IDLE;
            end
         end
         WB_REQ: begin
            if (mem_req_ready) begin
               state_s = WB_DATA;
            end else begin
               state_s = WB_REQ;
            end
         end
         WB_DATA: begin
            if (mem_wready && (beat_r == LAST_BEAT)) begin
               state_s = RD_REQ;
            end else begin
               state_s = WB_DATA;
            end
         end
         RD_REQ: begin
            if (mem_req_ready) begin
               state_s = RD_DATA;
            end else begin
               state_s = RD_REQ;
            end
         end
         RD_DATA: begin
            if (mem_rvalid && (beat_r == LAST_BEAT)) begin
               state_s = FILL;
            end else begin
               state_s = RD_DATA;
            end
         end
         FILL: begin
            if (fill_ready) begin
               state_s = IDLE;
            end else begin
               state_s = FILL;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Control outputs decoded purely from the registered state.
   always_comb begin
      miss_ready    = 1'b0;
      busy          = 1'b1;
      mem_req_valid = 1'b0;
      mem_req_we    = 1'b0;
      mem_req_addr  = miss_addr_r;
      mem_wvalid    = 1'b0;
      mem_rready    = 1'b0;
      fill_valid    = 1'b0;
      case (state_r)
         IDLE: begin
            miss_ready = 1'b1;
            busy       = 1'b0;
         end
         WB_REQ: begin
            mem_req_valid = 1'b1;
            mem_req_we    = 1'b1;
            mem_req_addr  = victim_addr_r;
         end
         WB_DATA: begin
            mem_wvalid = 1'b1;
         end
         RD_REQ: begin
            mem_req_valid = 1'b1;
         end
         RD_DATA: begin
            mem_rready = 1'b1;
         end
         FILL: begin
            fill_valid = 1'b1;
         end
         default: begin
            miss_ready = 1'b0;
         end
      endcase
   end

   assign mem_wdata = victim_data_r[beat_r];
   assign fill_addr = miss_addr_r;
   assign fill_data = line_r;

   // Miss capture, beat counting and line assembly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_r        <= BEAT_ZERO;
         miss_addr_r   <= {ADDR_W{1'b0}};
         victim_addr_r <= {ADDR_W{1'b0}};
         victim_data_r <= {(DATA_W*LINE_WORDS){1'b0}};
         line_r        <= {(DATA_W*LINE_WORDS){1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (miss_valid) begin
                  miss_addr_r   <= line_align(miss_addr);
                  victim_addr_r <= line_align(victim_addr);
                  victim_data_r <= victim_data;
               end
            end
            WB_REQ, RD_REQ: begin
               if (mem_req_ready) begin
                  beat_r <= BEAT_ZERO;
               end
            end
            WB_DATA: begin
               if (mem_wready) begin
                  beat_r <= beat_r + BEAT_ONE;
               end
            end
            RD_DATA: begin
               if (mem_rvalid) begin
                  line_r[beat_r] <= mem_rdata;
                  beat_r         <= beat_r + BEAT_ONE;
               end
            end
            default: begin
               beat_r <= beat_r;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Randomised scoreboard bench for cache_refill_ctrl with a memory responder.
module tb_cache_refill_ctrl;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int LW = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            miss_valid;
   logic            miss_ready;
   logic [AW-1:0]   miss_addr;
   logic            victim_dirty;
   logic [AW-1:0]   victim_addr;
   logic [DW*LW-1:0] victim_data;
   logic            mem_req_valid, mem_req_ready, mem_req_we;
   logic [AW-1:0]   mem_req_addr;
   logic            mem_wvalid, mem_wready;
   logic [DW-1:0]   mem_wdata;
   logic            mem_rvalid, mem_rready;
   logic [DW-1:0]   mem_rdata;
   logic            fill_valid, fill_ready;
   logic [AW-1:0]   fill_addr;
   logic [DW*LW-1:0] fill_data;
   logic            busy;

   cache_refill_ctrl #(.ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(LW)) dut (
      .clk(clk), .rst_n(rst_n),
      .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
      .victim_dirty(victim_dirty), .victim_addr(victim_addr), .victim_data(victim_data),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
      .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .mem_wdata(mem_wdata),
      .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rdata(mem_rdata),
      .fill_valid(fill_valid), .fill_ready(fill_ready),
      .fill_addr(fill_addr), .fill_data(fill_data), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed { logic we; logic [31:0] addr; } cmd_t;
   typedef struct packed { logic [31:0] addr; logic [127:0] data; } fill_t;

   cmd_t        exp_cmd[$];
   logic [31:0] exp_wb[$];
   fill_t       exp_fill[$];

   logic [31:0] model_mem [logic [31:0]];
   logic [31:0] resp_mem  [logic [31:0]];

   function automatic logic [31:0] dflt_word(input logic [31:0] a);
      return (a * 32'h0001_0003) ^ 32'hC0DE_0000;
   endfunction

   function automatic logic [31:0] model_rd(input logic [31:0] a);
      return model_mem.exists(a) ? model_mem[a] : dflt_word(a);
   endfunction

   function automatic logic [31:0] resp_rd(input logic [31:0] a);
      return resp_mem.exists(a) ? resp_mem[a] : dflt_word(a);
   endfunction

   // Expected memory traffic and fill for one accepted miss.
   task automatic predict(input logic [31:0] maddr, input logic dirty,
                          input logic [31:0] vaddr, input logic [127:0] vdata);
      logic [31:0]  mline;
      logic [31:0]  vline;
      logic [127:0] line;
      mline = maddr & 32'hFFFF_FFF0;
      vline = vaddr & 32'hFFFF_FFF0;
      if (dirty) begin
         exp_cmd.push_back('{we: 1'b1, addr: vline});
         for (int i = 0; i < LW; i++) begin
            exp_wb.push_back(vdata[i*32 +: 32]);
            model_mem[vline + 32'(4*i)] = vdata[i*32 +: 32];
         end
      end
      exp_cmd.push_back('{we: 1'b0, addr: mline});
      for (int i = 0; i < LW; i++) line[i*32 +: 32] = model_rd(mline + 32'(4*i));
      exp_fill.push_back('{addr: mline, data: line});
   endtask

   // ---------------- memory responder ----------------
   logic        stall_en = 1'b0;
   logic        spur_en  = 1'b0;
   int          rd_pending = 0, rd_idx = 0, wr_idx = 0;
   logic [31:0] rd_base = 32'h0, wr_base = 32'h0;

   initial begin
      mem_req_ready = 1'b0; mem_wready = 1'b0; mem_rvalid = 1'b0;
      mem_rdata = 32'h0; fill_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            rd_pending = 0; rd_idx = 0; wr_idx = 0;
         end else begin
            if (mem_req_valid && mem_req_ready) begin
               if (mem_req_we) begin wr_base = mem_req_addr; wr_idx = 0; end
               else begin rd_base = mem_req_addr; rd_idx = 0; rd_pending = LW; end
            end
            if (mem_wvalid && mem_wready) begin
               resp_mem[wr_base + 32'(4*wr_idx)] = mem_wdata;
               wr_idx++;
            end
            if (mem_rvalid && mem_rready) rd_idx++;
         end
         @(posedge clk); #1;
         mem_req_ready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
         mem_wready    = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
         fill_ready    = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
         if (rd_idx < rd_pending) begin
            mem_rvalid = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
            mem_rdata  = resp_rd(rd_base + 32'(4*rd_idx));
         end else if (spur_en) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'h0000_0BAD;
         end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = 32'($urandom);
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   logic         p_req_v = 1'b0, p_req_r = 1'b0, p_req_we = 1'b0;
   logic [31:0]  p_req_a = 32'h0;
   logic         p_w_v = 1'b0, p_w_r = 1'b0;
   logic [31:0]  p_w_d = 32'h0;
   logic         p_f_v = 1'b0, p_f_r = 1'b0;
   logic [31:0]  p_f_a = 32'h0;
   logic [127:0] p_f_d = 128'h0;
   logic         p_fill_hs = 1'b0;
   int           fill_rise_cyc = 0, fill_hs_cyc = 0, n_fill_hs = 0;
   logic [31:0]  last_fill_addr = 32'h0;
   logic [127:0] last_fill_data = 128'h0;
   cmd_t         c;
   fill_t        f;
   logic [31:0]  w;

   always @(negedge clk) begin
      if (rst_n) begin
         check("ready_vs_busy", miss_ready, !busy);
         if (p_req_v && !p_req_r)
            check("req_hold", {mem_req_valid, mem_req_we, mem_req_addr}, {1'b1, p_req_we, p_req_a});
         if (p_w_v && !p_w_r)
            check("wbeat_hold", {mem_wvalid, mem_wdata}, {1'b1, p_w_d});
         if (p_f_v && !p_f_r)
            check("fill_hold", {fill_valid, fill_addr, fill_data}, {1'b1, p_f_a, p_f_d});
         if (p_fill_hs)
            check("idle_after_fill", {miss_ready, busy}, 2'b10);
         if (mem_rvalid && !busy)
            check("spurious_rready", mem_rready, 1'b0);
         if (mem_req_valid && mem_req_ready) begin
            if (exp_cmd.size() == 0) check("unexpected_cmd", 1'b1, 1'b0);
            else begin
               c = exp_cmd.pop_front();
               check("mem_cmd", {mem_req_we, mem_req_addr}, {c.we, c.addr});
            end
         end
         if (mem_wvalid && mem_wready) begin
            if (exp_wb.size() == 0) check("unexpected_wbeat", 1'b1, 1'b0);
            else begin
               w = exp_wb.pop_front();
               check("wbeat", mem_wdata, w);
            end
         end
         if (fill_valid && !p_f_v) fill_rise_cyc = cyc;
         if (fill_valid && fill_ready) begin
            n_fill_hs++;
            fill_hs_cyc    = cyc;
            last_fill_addr = fill_addr;
            last_fill_data = fill_data;
            if (exp_fill.size() == 0) check("unexpected_fill", 1'b1, 1'b0);
            else begin
               f = exp_fill.pop_front();
               check("fill", {fill_addr, fill_data}, {f.addr, f.data});
            end
         end
         p_req_v = mem_req_valid; p_req_r = mem_req_ready; p_req_we = mem_req_we; p_req_a = mem_req_addr;
         p_w_v = mem_wvalid; p_w_r = mem_wready; p_w_d = mem_wdata;
         p_f_v = fill_valid; p_f_r = fill_ready; p_f_a = fill_addr; p_f_d = fill_data;
         p_fill_hs = fill_valid && fill_ready;
      end else begin
         p_req_v = 1'b0; p_w_v = 1'b0; p_f_v = 1'b0; p_fill_hs = 1'b0;
      end
   end

   // ---------------- stimulus ----------------
   task automatic do_miss(input logic [31:0] maddr, input logic dirty,
                          input logic [31:0] vaddr, input logic [127:0] vdata,
                          output int acc_cyc);
      logic acc;
      @(posedge clk); #1;
      miss_valid = 1'b1; miss_addr = maddr; victim_dirty = dirty;
      victim_addr = vaddr; victim_data = vdata;
      acc = 1'b0;
      acc_cyc = 0;
      for (int k = 0; k < 3000 && !acc; k++) begin
         @(negedge clk);
         if (miss_ready) begin
            acc = 1'b1;
            acc_cyc = cyc;
            predict(maddr, dirty, vaddr, vdata);
         end
      end
      if (!acc) check("miss_accept_timeout", 1'b0, 1'b1);
      @(posedge clk); #1;
      miss_valid = 1'b0; miss_addr = 32'($urandom); victim_dirty = 1'($urandom);
      victim_addr = 32'($urandom);
   endtask

   task automatic drain(input string name);
      logic done;
      done = 1'b0;
      for (int k = 0; k < 4000 && !done; k++) begin
         @(negedge clk);
         if (exp_cmd.size() == 0 && exp_wb.size() == 0 && exp_fill.size() == 0 && !busy)
            done = 1'b1;
      end
      check(name, done, 1'b1);
   endtask

   int acc_a, acc_b, snap;
   logic hit;

   initial begin
      rst_n = 1'b0; miss_valid = 1'b0; miss_addr = 32'h0; victim_dirty = 1'b0;
      victim_addr = 32'h0; victim_data = 128'h0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ctrl", {miss_ready, busy, mem_req_valid, mem_wvalid, mem_rready, fill_valid}, 6'b100000);
      check("rst_data", {fill_addr, fill_data, mem_req_addr}, 192'h0);
      @(negedge clk); rst_n = 1'b1;

      // Clean miss, always-ready memory, known line contents.
      for (int i = 0; i < LW; i++) begin
         resp_mem[32'h1000 + 32'(4*i)]  = 32'(8'h11 * (i + 1));
         model_mem[32'h1000 + 32'(4*i)] = 32'(8'h11 * (i + 1));
      end
      do_miss(32'h0000_1004, 1'b0, 32'h0000_5000, 128'h0, acc_a);
      drain("drain_clean");
      check("clean_latency", 32'(fill_rise_cyc - acc_a), 32'd6);
      check("clean_fill_addr", last_fill_addr, 32'h0000_1000);
      check("clean_fill_data", last_fill_data, 128'h00000044_00000033_00000022_00000011);

      // Dirty miss: write-back of A,B,C,D then refill.
      do_miss(32'h0000_1000, 1'b1, 32'h0000_2008,
              128'h0000000D_0000000C_0000000B_0000000A, acc_a);
      drain("drain_dirty");
      check("dirty_latency", 32'(fill_rise_cyc - acc_a), 32'd11);
      check("dirty_wb_mem", {resp_rd(32'h2000), resp_rd(32'h200C)}, 64'h0000000A_0000000D);

      // Spurious read data while idle must be ignored.
      spur_en = 1'b1;
      repeat (6) @(posedge clk);
      do_miss(32'h0000_1008, 1'b0, 32'h0, 128'h0, acc_a);
      drain("drain_spurious");
      check("spur_fill_data", last_fill_data, 128'h00000044_00000033_00000022_00000011);

      // Back-to-back: second miss held while busy, taken the cycle after fill.
      do_miss(32'h0000_3010, 1'b1, 32'h0000_4020, {$urandom, $urandom, $urandom, $urandom}, acc_a);
      do_miss(32'h0000_4024, 1'b0, 32'h0, 128'h0, acc_b);
      check("b2b_accept_gap", 32'(acc_b - fill_hs_cyc), 32'd1);
      drain("drain_b2b");

      // Randomised traffic with stalls on every handshake.
      stall_en = 1'b1;
      for (int n = 0; n < 30; n++) begin
         do_miss(32'($urandom_range(0, 511)), 1'($urandom), 32'($urandom_range(0, 511)),
                 {$urandom, $urandom, $urandom, $urandom}, acc_a);
      end
      drain("drain_random");

      // Reset in the middle of a read burst.
      stall_en = 1'b0; spur_en = 1'b0;
      do_miss(32'h0000_6000, 1'b0, 32'h0, 128'h0, acc_a);
      hit = 1'b0;
      for (int k = 0; k < 200 && !hit; k++) begin
         @(posedge clk); #2;
         if (rd_idx == 2) hit = 1'b1;
      end
      check("reach_beat2", hit, 1'b1);
      snap = n_fill_hs;
      rst_n = 1'b0;
      #1;
      check("midrst_ctrl", {miss_ready, busy, mem_req_valid, mem_wvalid, mem_rready, fill_valid}, 6'b100000);
      check("midrst_data", {fill_addr, fill_data}, 160'h0);
      exp_cmd.delete(); exp_wb.delete(); exp_fill.delete();
      rd_pending = 0; rd_idx = 0;
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      repeat (8) @(negedge clk);
      check("midrst_no_fill", n_fill_hs, snap);
      do_miss(32'h0000_1000, 1'b0, 32'h0, 128'h0, acc_a);
      drain("drain_after_reset");
      check("post_rst_fill", last_fill_data, 128'h00000044_00000033_00000022_00000011);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
